// File: rtl/axis_pkt_reader_if.sv
// Stream-in / buffer-read-out bundle for axis_pkt_reader.
// The slave modport is the packet reader; the master modport is upstream plus the host-side reader.
interface axis_pkt_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tlast;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  pkt_ready;
    logic [ADDR_WIDTH:0]   pkt_len;
    logic                  pkt_trunc;
    logic                  pkt_ack;
    logic [15:0]           pkt_cnt;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_addr, pkt_ack,
        output s_axis_tready, rd_data, pkt_ready, pkt_len, pkt_trunc, pkt_cnt
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_addr, pkt_ack,
        input  s_axis_tready, rd_data, pkt_ready, pkt_len, pkt_trunc, pkt_cnt
    );
endinterface

// File: rtl/axis_pkt_reader.sv
// Store-and-forward AXI4-Stream packet sink: captures one packet into a RAM,
// holds it (with back-pressure) for random-access reads until acknowledged.
module axis_pkt_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic               s_aclk,
    input  logic               s_aresetn,
    axis_pkt_reader_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  run_q;
    logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   len_q, len_nxt;
    logic                  trunc_q, trunc_nxt;
    logic [15:0]           cnt_q, cnt_nxt;
    logic                  we;
    logic                  hs;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;

    // run_q keeps tready low while reset is held, since RECV alone would assert it.
    assign bus.s_axis_tready = run_q && (state != HOLD);
    assign bus.pkt_ready     = (state == HOLD);
    assign bus.pkt_len       = len_q;
    assign bus.pkt_trunc     = trunc_q;
    assign bus.pkt_cnt       = cnt_q;
    assign bus.rd_data       = rd_q;

    assign hs = bus.s_axis_tvalid && bus.s_axis_tready;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        len_nxt    = len_q;
        trunc_nxt  = trunc_q;
        cnt_nxt    = cnt_q;
        we         = 1'b0;
        case (state)
            RECV: begin
                if (hs) begin
                    we         = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_ONE;
                    if (bus.s_axis_tlast) begin
                        len_nxt   = wr_ptr + PTR_ONE;
                        trunc_nxt = 1'b0;
                        cnt_nxt   = cnt_q + 16'd1;
                        state_nxt = HOLD;
                    end else if (wr_ptr == PTR_LAST) begin
                        // Buffer just filled without tlast: keep what we have, swallow the rest.
                        len_nxt   = FULL_LEN;
                        trunc_nxt = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (hs && bus.s_axis_tlast) begin
                    cnt_nxt   = cnt_q + 16'd1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.pkt_ack) begin
                    wr_ptr_nxt = '0;
                    state_nxt  = RECV;
                end
            end
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state   <= RECV;
            run_q   <= 1'b0;
            wr_ptr  <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            run_q   <= 1'b1;
            wr_ptr  <= wr_ptr_nxt;
            len_q   <= len_nxt;
            trunc_q <= trunc_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge s_aclk) begin
        if (we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.s_axis_tdata;
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) rd_q <= '0;
        else            rd_q <= mem[bus.rd_addr];
    end
endmodule

// File: tb/tb_axis_pkt_reader.sv
// Directed bench for axis_pkt_reader: hand-computed expectations checked with immediate assertions.
module tb_axis_pkt_reader;
    logic clk;
    logic rstn;
    int   vectors = 0;
    int   errors  = 0;

    axis_pkt_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

    axis_pkt_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
        .s_aclk    (clk),
        .s_aresetn (rstn),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat after an idle gap; wait (bounded) for tready, then take the handshake edge.
    task automatic send(input logic [31:0] d, input logic last, input int gap);
        int n;
        bus.s_axis_tvalid = 1'b0;
        repeat (gap) tick();
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        n = 0;
        while (bus.s_axis_tready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("tready_wait", {63'd0, bus.s_axis_tready}, 64'd1);
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        bus.rd_addr = a;
        tick();
        check(tag, {32'd0, bus.rd_data}, {32'd0, exp});
    endtask

    task automatic ack();
        bus.pkt_ack = 1'b1;
        tick();
        bus.pkt_ack = 1'b0;
        check("ack_ready", {63'd0, bus.pkt_ready}, 64'd0);
        check("ack_tready", {63'd0, bus.s_axis_tready}, 64'd1);
    endtask

    task automatic check_held(input string tag, input logic [7:0] len, input logic trunc,
                              input logic [15:0] cnt);
        check({tag, "_ready"}, {63'd0, bus.pkt_ready}, 64'd1);
        check({tag, "_tready"}, {63'd0, bus.s_axis_tready}, 64'd0);
        check({tag, "_len"}, {56'd0, bus.pkt_len}, {56'd0, len});
        check({tag, "_trunc"}, {63'd0, bus.pkt_trunc}, {63'd0, trunc});
        check({tag, "_cnt"}, {48'd0, bus.pkt_cnt}, {48'd0, cnt});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tready"}, {63'd0, bus.s_axis_tready}, 64'd0);
        check({tag, "_ready"}, {63'd0, bus.pkt_ready}, 64'd0);
        check({tag, "_len"}, {56'd0, bus.pkt_len}, 64'd0);
        check({tag, "_trunc"}, {63'd0, bus.pkt_trunc}, 64'd0);
        check({tag, "_cnt"}, {48'd0, bus.pkt_cnt}, 64'd0);
        check({tag, "_rdata"}, {32'd0, bus.rd_data}, 64'd0);
    endtask

    initial begin
        rstn              = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.rd_addr       = '0;
        bus.pkt_ack       = 1'b0;

        // Reset state
        repeat (3) tick();
        check_reset("rst");
        rstn = 1'b1;
        tick();
        check("rst_rel_tready", {63'd0, bus.s_axis_tready}, 64'd1);

        // Single-beat packet
        send(32'hDEADBEEF, 1'b1, 0);
        check_held("single", 8'd1, 1'b0, 16'd1);
        rd_chk("single_rd0", 7'd0, 32'hDEADBEEF);
        check("single_hold_tready", {63'd0, bus.s_axis_tready}, 64'd0);
        ack();

        // Back-to-back packets of 5 then 3 words with throttled tvalid
        for (int i = 0; i < 5; i++)
            send(32'h1000_0000 + i, i == 4, $urandom_range(0, 2));
        check_held("p5", 8'd5, 1'b0, 16'd2);
        ack();
        for (int i = 0; i < 5; i++)
            rd_chk("p5_rd", 7'(i), 32'h1000_0000 + i);
        for (int i = 0; i < 3; i++)
            send(32'h2000_0000 + i, i == 2, $urandom_range(0, 2));
        check_held("p3", 8'd3, 1'b0, 16'd3);
        for (int i = 0; i < 3; i++)
            rd_chk("p3_rd", 7'(i), 32'h2000_0000 + i);
        ack();

        // Exact capacity: goes straight to HOLD on word 128
        for (int i = 0; i < 128; i++)
            send(32'hC000_0000 + i, i == 127, 0);
        check_held("full", 8'h80, 1'b0, 16'd4);
        rd_chk("full_rd0", 7'd0, 32'hC000_0000);
        rd_chk("full_rd127", 7'd127, 32'hC000_007F);
        ack();

        // Oversize: 200 words, only the first 128 kept
        for (int i = 0; i < 199; i++)
            send(32'hD000_0000 + i, 1'b0, $urandom_range(0, 1));
        check("over_not_held", {63'd0, bus.pkt_ready}, 64'd0);
        send(32'hD000_00C7, 1'b1, 0);
        check_held("over", 8'h80, 1'b1, 16'd5);
        rd_chk("over_rd0", 7'd0, 32'hD000_0000);
        rd_chk("over_rd127", 7'd127, 32'hD000_007F);
        ack();

        // Back-pressure in HOLD, then a stray ack mid-packet in RECV
        send(32'hE000_0000, 1'b0, 0);
        send(32'hE000_0001, 1'b1, 0);
        check_held("bp", 8'd2, 1'b0, 16'd6);
        bus.s_axis_tdata  = 32'hBAD0_BAD0;
        bus.s_axis_tlast  = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        repeat (5) begin
            tick();
            check("bp_tready", {63'd0, bus.s_axis_tready}, 64'd0);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        check_held("bp_after", 8'd2, 1'b0, 16'd6);
        rd_chk("bp_rd0", 7'd0, 32'hE000_0000);
        rd_chk("bp_rd1", 7'd1, 32'hE000_0001);
        ack();
        send(32'hF000_0000, 1'b0, 0);
        bus.pkt_ack = 1'b1;
        tick();
        bus.pkt_ack = 1'b0;
        check("stray_ready", {63'd0, bus.pkt_ready}, 64'd0);
        check("stray_tready", {63'd0, bus.s_axis_tready}, 64'd1);
        send(32'hF000_0001, 1'b1, 0);
        check_held("stray", 8'd2, 1'b0, 16'd7);
        rd_chk("stray_rd0", 7'd0, 32'hF000_0000);
        rd_chk("stray_rd1", 7'd1, 32'hF000_0001);
        ack();

        // Reset mid-packet: remaining 6 beats form a fresh packet
        for (int i = 0; i < 4; i++)
            send(32'h3000_0000 + i, 1'b0, 0);
        rstn = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        tick();
        check_reset("midrst_hold");
        rstn = 1'b1;
        tick();
        check("midrst_rel_tready", {63'd0, bus.s_axis_tready}, 64'd1);
        for (int i = 0; i < 6; i++)
            send(32'h4000_0000 + i, i == 5, $urandom_range(0, 1));
        check_held("midrst_pkt", 8'd6, 1'b0, 16'd1);
        rd_chk("midrst_rd0", 7'd0, 32'h4000_0000);
        rd_chk("midrst_rd5", 7'd5, 32'h4000_0005);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
